// File: rtl/title_text_buffer.sv
// Title glyph feeder: ASCII/edit stream -> twelve glyph ROM base addresses, committed at frame start.
// Latency: an accepted edit reaches charN on the first commit edge after acceptance (min 1 cycle).
// Backpressure: in_ready drops for the 12-cycle clear sweep; other commands are always accepted.
module title_text_buffer #(
    parameter int GLYPH_SHIFT = 3,
    parameter int BLANK_INDEX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_cmd,
    input  logic [7:0] in_ascii,
    input  logic       frame_start,
    output logic [8:0] char1,
    output logic [8:0] char2,
    output logic [8:0] char3,
    output logic [8:0] char4,
    output logic [8:0] char5,
    output logic [8:0] char6,
    output logic [8:0] char7,
    output logic [8:0] char8,
    output logic [8:0] char9,
    output logic [8:0] char10,
    output logic [8:0] char11,
    output logic [8:0] char12,
    output logic [3:0] cursor,
    output logic       full,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [8:0] BLANK_ADDR = 9'(BLANK_INDEX << GLYPH_SHIFT);

    logic [0:0] state;
    logic [3:0] cursor_q;
    logic [3:0] clr_idx;
    logic       busy_q;
    logic       dirty;
    logic [8:0] shadow [12];
    logic [8:0] disp   [12];
    logic [8:0] wr_addr;
    logic       accept;
    logic       commit;

    function automatic logic [8:0] glyph_addr(input logic [7:0] c);
        logic [8:0] idx;
        idx = 9'(BLANK_INDEX);
        if (c == 8'h20)                      idx = 9'd0;
        else if (c >= 8'h41 && c <= 8'h5a)   idx = 9'(c - 8'h40);
        else if (c >= 8'h61 && c <= 8'h7a)   idx = 9'(c - 8'h60);
        else if (c >= 8'h30 && c <= 8'h39)   idx = 9'(c - 8'h15);
        else if (c == 8'h23)                 idx = 9'd37;
        else if (c == 8'h2d)                 idx = 9'd38;
        else if (c == 8'h2e)                 idx = 9'd39;
        return 9'(idx << GLYPH_SHIFT);
    endfunction

    assign wr_addr  = glyph_addr(in_ascii);
    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign commit   = frame_start && (state == ST_IDLE) && dirty;
    assign cursor   = cursor_q;
    assign full     = (cursor_q == 4'd12);
    assign busy     = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cursor_q <= 4'd0;
            clr_idx  <= 4'd0;
            busy_q   <= 1'b0;
            dirty    <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                shadow[i] <= BLANK_ADDR;
                disp[i]   <= BLANK_ADDR;
            end
        end else begin
            // Commit samples the pre-edit shadow; an edit on the same edge re-arms dirty below.
            if (commit) begin
                for (int i = 0; i < 12; i++) disp[i] <= shadow[i];
                dirty <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (in_cmd)
                            2'b00: if (cursor_q < 4'd12) begin
                                shadow[cursor_q] <= wr_addr;
                                cursor_q         <= cursor_q + 4'd1;
                                dirty            <= 1'b1;
                            end
                            2'b01: if (cursor_q != 4'd0) begin
                                shadow[cursor_q - 4'd1] <= BLANK_ADDR;
                                cursor_q                <= cursor_q - 4'd1;
                                dirty                   <= 1'b1;
                            end
                            2'b10: begin
                                state    <= ST_CLEAR;
                                cursor_q <= 4'd0;
                                busy_q   <= 1'b1;
                                clr_idx  <= 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    shadow[clr_idx] <= BLANK_ADDR;
                    if (clr_idx == 4'd11) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        dirty  <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign char1  = disp[0];
    assign char2  = disp[1];
    assign char3  = disp[2];
    assign char4  = disp[3];
    assign char5  = disp[4];
    assign char6  = disp[5];
    assign char7  = disp[6];
    assign char8  = disp[7];
    assign char9  = disp[8];
    assign char10 = disp[9];
    assign char11 = disp[10];
    assign char12 = disp[11];

endmodule

// File: tb/tb_title_text_buffer.sv
// Bench for title_text_buffer: directed plan steps followed by random command traffic,
// all compared against a slot-array reference model.
module tb_title_text_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_cmd = 2'b11;
    logic [7:0] in_ascii = 8'd0;
    logic       frame_start = 1'b0;
    logic       in_ready, full, busy;
    logic [3:0] cursor;
    logic [8:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12;
    logic [8:0] ch [12];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: slot contents as plain ints, clear modelled as a countdown.
    int m_sh [12];
    int m_dp [12];
    int m_cur, m_dirty, m_busy;

    title_text_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_ascii(in_ascii), .frame_start(frame_start),
        .char1(c1), .char2(c2), .char3(c3), .char4(c4), .char5(c5), .char6(c6),
        .char7(c7), .char8(c8), .char9(c9), .char10(c10), .char11(c11), .char12(c12),
        .cursor(cursor), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch[0] = c1;  ch[1] = c2;  ch[2]  = c3;  ch[3]  = c4;
        ch[4] = c5;  ch[5] = c6;  ch[6]  = c7;  ch[7]  = c8;
        ch[8] = c9;  ch[9] = c10; ch[10] = c11; ch[11] = c12;
    end

    function automatic int ref_addr(input int c);
        int idx;
        if (c == 32)                  idx = 0;
        else if (c >= 65 && c <= 90)  idx = c - 64;
        else if (c >= 97 && c <= 122) idx = c - 96;
        else if (c >= 48 && c <= 57)  idx = 27 + (c - 48);
        else if (c == 35)             idx = 37;
        else if (c == 45)             idx = 38;
        else if (c == 46)             idx = 39;
        else                          idx = 0;
        return (idx * 8) % 512;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            m_sh[i] = 0;
            m_dp[i] = 0;
        end
        m_cur = 0; m_dirty = 0; m_busy = 0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] cmd, input logic [7:0] a, input logic fs);
        bit idle;
        idle = (m_busy == 0);
        if (fs && idle && m_dirty != 0) begin
            for (int i = 0; i < 12; i++) m_dp[i] = m_sh[i];
            m_dirty = 0;
        end
        if (idle) begin
            if (v) begin
                if (cmd == 2'd0 && m_cur < 12) begin
                    m_sh[m_cur] = ref_addr(int'(a));
                    m_cur++;
                    m_dirty = 1;
                end else if (cmd == 2'd1 && m_cur > 0) begin
                    m_cur--;
                    m_sh[m_cur] = 0;
                    m_dirty = 1;
                end else if (cmd == 2'd2) begin
                    m_cur  = 0;
                    m_busy = 12;
                end
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                for (int i = 0; i < 12; i++) m_sh[i] = 0;
                m_dirty = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
        chk("busy", 32'(busy), 32'(m_busy != 0));
        chk("cursor", 32'(cursor), 32'(m_cur));
        chk("full", 32'(full), 32'(m_cur == 12));
        for (int i = 0; i < 12; i++) chk($sformatf("char%0d", i + 1), 32'(ch[i]), 32'(m_dp[i]));
    endtask

    task automatic step(input logic v, input logic [1:0] cmd, input logic [7:0] a, input logic fs);
        in_valid = v; in_cmd = cmd; in_ascii = a; frame_start = fs;
        @(posedge clk);
        model_edge(v, cmd, a, fs);
        #1;
        in_valid = 1'b0; in_cmd = 2'b11; in_ascii = 8'd0; frame_start = 1'b0;
        check_all();
    endtask

    task automatic wr_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, 2'b00, s[i], 1'b0);
    endtask

    task automatic do_clear();
        step(1'b1, 2'b10, 8'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 2'b11, 8'd0, 1'b0);
    endtask

    initial begin
        logic v, fs;
        logic [1:0] cmd;
        logic [7:0] a;
        int r;

        model_reset();
        #12 rst_n = 1'b1;
        #1 check_all();

        // "Piano": invisible until frame_start
        wr_str("Piano");
        step(1'b0, 2'b11, 8'd0, 1'b1);
        chk("piano_c1", 32'(c1), 32'd128);
        chk("piano_c2", 32'(c2), 32'd72);
        chk("piano_c3", 32'(c3), 32'd8);
        chk("piano_c4", 32'(c4), 32'd112);
        chk("piano_c5", 32'(c5), 32'd120);
        chk("piano_c6", 32'(c6), 32'd0);

        // Overflow: 13th char accepted but dropped
        do_clear();
        wr_str("ABCDEFGHIJKL");
        chk("full_ready", 32'(in_ready), 32'd1);
        step(1'b1, 2'b00, "M", 1'b0);
        step(1'b0, 2'b11, 8'd0, 1'b1);
        for (int i = 0; i < 12; i++) chk($sformatf("abc_c%0d", i + 1), 32'(ch[i]), 32'(8 * (i + 1)));
        chk("abc_full", 32'(full), 32'd1);
        chk("abc_cursor", 32'(cursor), 32'd12);

        // Backspace at 0, then "9#" + backspace
        do_clear();
        step(1'b0, 2'b11, 8'd0, 1'b1);
        step(1'b1, 2'b01, 8'd0, 1'b0);
        step(1'b0, 2'b11, 8'd0, 1'b1);
        wr_str("9#");
        step(1'b1, 2'b01, 8'd0, 1'b0);
        step(1'b0, 2'b11, 8'd0, 1'b1);
        chk("bs_c1", 32'(c1), 32'd288);
        chk("bs_c2", 32'(c2), 32'd0);
        chk("bs_cursor", 32'(cursor), 32'd1);

        // frame_start during clear is ignored, display keeps DRUMS
        do_clear();
        wr_str("DRUMS");
        step(1'b0, 2'b11, 8'd0, 1'b1);
        step(1'b1, 2'b10, 8'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 2'b11, 8'd0, i == 4);
        chk("drums_kept_c1", 32'(c1), 32'd32);
        step(1'b0, 2'b11, 8'd0, 1'b1);
        chk("drums_cleared_c1", 32'(c1), 32'd0);

        // Write on the same edge as a commit with dirty=0
        step(1'b1, 2'b00, "-", 1'b1);
        chk("dash_same_edge", 32'(c1), 32'd0);
        step(1'b0, 2'b11, 8'd0, 1'b1);
        chk("dash_next_frame", 32'(c1), 32'd304);

        // Async reset mid-clear
        wr_str("AB");
        step(1'b0, 2'b11, 8'd0, 1'b1);
        step(1'b1, 2'b10, 8'd0, 1'b0);
        step(1'b0, 2'b11, 8'd0, 1'b0);
        step(1'b0, 2'b11, 8'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_c1", 32'(c1), 32'd0);
        #1 rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 19);
            cmd = (r < 13) ? 2'b00 : (r < 17) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
            fs = ($urandom_range(0, 5) == 0);
            step(v, cmd, a, fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/title_text_buffer.md
Name: title_text_buffer

Overview:
- Upstream feeder for the title display stage: turns an ASCII character stream plus edit commands into the twelve 9-bit glyph ROM base addresses (char1..char12) that the title renderer draws.
- Keeps a shadow (edit) buffer and a display buffer.
- The display buffer is updated only on a frame-start pulse, so a title never changes mid-frame.
- Instantiated once for the song title and once for the instrument title.

Parameters:
- GLYPH_SHIFT, 3: log2 of rows per glyph. base address = glyph_index << GLYPH_SHIFT.
- BLANK_INDEX, 0: glyph index used for space, unmapped codes, and cleared slots.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command/character valid
- in_ready  output  1  block can accept a command this cycle
- in_cmd  input  2  00 write char, 01 backspace, 10 clear, 11 no-op
- in_ascii  input  8  ASCII code; used only when in_cmd=00
- frame_start  input  1  one-cycle pulse at start of vertical blanking
- char1..char12  output  9 each  display-buffer ROM base addresses; char1 is leftmost
- cursor  output  4  next write slot, 0..12
- full  output  1  cursor==12
- busy  output  1  clear sequence in progress

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n. All state is reset by rst_n and is otherwise updated on the rising edge of clk.
- Reset values:
  - all shadow and display slots = BLANK_INDEX<<GLYPH_SHIFT (9'd0)
  - cursor=0, full=0, busy=0, dirty=0
  - in_ready=1 once rst_n deasserts
  - FSM state = IDLE
- Handshake: a command is accepted on a rising edge where in_valid && in_ready. in_ready = (state==IDLE). in_ready does not depend on in_valid.
- ASCII to glyph index mapping (combinational):
  - 0x20 (space) → 0
  - 'A'-'Z' → 1..26; 'a'-'z' fold to the same 1..26
  - '0'-'9' → 27..36
  - '#' → 37, '-' → 38, '.' → 39
  - any other code → BLANK_INDEX
  - address = index<<GLYPH_SHIFT, truncated to 9 bits
- Write char (cmd 00):
  - If cursor<12: shadow[cursor] <= address, cursor <= cursor+1, dirty <= 1.
  - If cursor==12: the command is accepted and discarded; no state change.
- Backspace (cmd 01):
  - If cursor>0: cursor <= cursor-1, shadow[cursor-1] <= blank, dirty <= 1.
  - At cursor 0: no-op.
- Clear (cmd 10):
  - IDLE → CLEAR; cursor <= 0, busy <= 1.
  - In CLEAR, one shadow slot is blanked per cycle using an internal index 0..11. That takes 12 cycles; after slot 11 the FSM returns to IDLE, busy <= 0, dirty <= 1.
  - in_ready=0 throughout CLEAR.
- Commit: on a cycle with frame_start=1, state==IDLE and dirty=1, all 12 display slots <= shadow slots and dirty <= 0.
  - char outputs are driven directly from display registers.
  - Latency: a write accepted at edge T is visible on charN at the first commit edge after T. Minimum is 1 cycle, when frame_start occurs on the cycle after acceptance.
- Boundary conditions:
  - Write accepted on the same edge as a commit: the commit copies the pre-write shadow, and dirty stays 1 so the write appears at the next frame_start.
  - frame_start during CLEAR: ignored; dirty is preserved and the commit happens at the next frame_start after CLEAR ends.
  - frame_start with dirty=0: no display change.
  - rst_n asserted mid-CLEAR or at any time: immediate return to reset values regardless of clk.
  - full = (cursor==12), combinational from the cursor register.
- FSM: 2 states, IDLE and CLEAR. The clear index is 4 bits wide and is unused in IDLE.

Test Plan:
- Reset → all charN=0, cursor=0, in_ready=1.
- Write "Piano", then frame_start → char1..char5 = 128, 72, 8, 112, 120; char6..12 = 0; cursor=5. Before frame_start, all charN are still 0.
- Write 13 chars "ABCDEFGHIJKLM", then frame_start → char1..12 = 8..96 in steps of 8; the 'M' write is accepted (in_ready high) but dropped; full=1, cursor=12.
- Backspace at cursor 0 → no change and dirty stays 0. Then write "9#", backspace, frame_start → char1=288, char2=0, cursor=1.
- Load "DRUMS" and commit. Issue clear, pulse frame_start on clear cycle 5 → in_ready=0 and busy=1 for 12 cycles; display still shows DRUMS. The next frame_start → all charN=0.
- Write '-' on the same edge as a frame_start (dirty was 0) → char1 stays 0. The next frame_start → char1=304.
- Assert rst_n low asynchronously mid-clear → outputs return to 0 before the next clk edge.
